// File: rtl/comp_sched_pkg.sv
// rtl/comp_sched_pkg.sv - shared opcodes, stage types and helpers for comp_sched_real
`ifndef GT_OPCODE_REAL
`define GT_OPCODE_REAL 3'd0
`endif
`ifndef GE_OPCODE_REAL
`define GE_OPCODE_REAL 3'd1
`endif
`ifndef LT_OPCODE_REAL
`define LT_OPCODE_REAL 3'd2
`endif
`ifndef LE_OPCODE_REAL
`define LE_OPCODE_REAL 3'd3
`endif
`ifndef EQ_OPCODE_REAL
`define EQ_OPCODE_REAL 3'd4
`endif
`ifndef NE_OPCODE_REAL
`define NE_OPCODE_REAL 3'd5
`endif

package comp_sched_pkg;
    localparam int OP_W     = 3;
    localparam int ID_MAX_W = 8;
    localparam int AL_W     = 32;

    localparam logic [OP_W-1:0] OP_GT = `GT_OPCODE_REAL;
    localparam logic [OP_W-1:0] OP_GE = `GE_OPCODE_REAL;
    localparam logic [OP_W-1:0] OP_LT = `LT_OPCODE_REAL;
    localparam logic [OP_W-1:0] OP_LE = `LE_OPCODE_REAL;
    localparam logic [OP_W-1:0] OP_EQ = `EQ_OPCODE_REAL;
    localparam logic [OP_W-1:0] OP_NE = `NE_OPCODE_REAL;

    function automatic int ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Stage fields are sized for the widest supported configuration.
    typedef struct packed {
        logic                  valid;
        logic [ID_MAX_W-1:0]   id;
        logic [OP_W-1:0]       op;
        logic signed [AL_W-1:0] a_al;
        logic signed [AL_W-1:0] b_al;
    } s1_t;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic                c;
        logic                err;
    } s2_t;
endpackage

// File: rtl/comp_sched_real_rr_arb.sv
// rtl/comp_sched_real_rr_arb.sv - round-robin pointer and one-hot grant
module rr_arb
    import comp_sched_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cke,
    input  logic [n-1:0] req,
    output logic [n-1:0] gnt,
    input  logic         advance
);
    localparam int IW = ID_W(n);

    logic [IW-1:0] ptr;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] idx;
    logic          found;

    // Scan starts one past the last winner so every requester is served once per round.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= n; k++) begin
            idx = IW'((int'(ptr) + k) % n);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (found && cke && !rst)
            gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= IW'(n - 1);
        else if (cke && advance)
            ptr <= gnt_idx;
    end
endmodule

// File: rtl/comp_sched_real.sv
// rtl/comp_sched_real.sv - shared fixed-point comparator, RR arbitrated; COMP_SCHED_STATS_EN adds counters
module comp_sched_real
    import comp_sched_pkg::*;
#(
    parameter int  n_req      = 4,
    parameter int  a_width    = 16,
    parameter int  a_exponent = -8,
    parameter real a_range    = 128.0,
    parameter int  b_width    = 16,
    parameter int  b_exponent = -10,
    parameter real b_range    = 32.0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cke,
    input  logic [n_req-1:0]                req_valid,
    output logic [n_req-1:0]                req_ready,
    input  logic [n_req-1:0][OP_W-1:0]      req_op,
    input  logic [n_req-1:0][a_width-1:0]   req_a,
    input  logic [n_req-1:0][b_width-1:0]   req_b,
    output logic [n_req-1:0]                rsp_valid,
    output logic                            rsp_c,
    output logic                            rsp_err
`ifdef COMP_SCHED_STATS_EN
    ,
    output logic [31:0]                     stat_done,
    output logic [15:0]                     stat_err
`endif
);
    // Common format takes the exponent of the operand with the larger range.
    localparam int AL_EXP = (a_range >= b_range) ? a_exponent : b_exponent;
    localparam int SH_A   = a_exponent - AL_EXP;
    localparam int SH_B   = b_exponent - AL_EXP;

    function automatic logic signed [AL_W-1:0] align(input logic signed [AL_W-1:0] v, input int sh);
        return (sh >= 0) ? (v <<< sh) : (v >>> (-sh));
    endfunction

    s1_t s1;
    s2_t s2;

    logic                   advance;
    logic [ID_MAX_W-1:0]    sel_id;
    logic [OP_W-1:0]        sel_op;
    logic signed [AL_W-1:0] sel_a;
    logic signed [AL_W-1:0] sel_b;

    rr_arb #(.n(n_req)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .cke     (cke),
        .req     (req_valid),
        .gnt     (req_ready),
        .advance (advance)
    );

    assign advance = |req_ready;

    always_comb begin
        sel_id = '0;
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < n_req; i++) begin
            if (req_ready[i]) begin
                sel_id = ID_MAX_W'(i);
                sel_op = req_op[i];
                sel_a  = align(AL_W'($signed(req_a[i])), SH_A);
                sel_b  = align(AL_W'($signed(req_b[i])), SH_B);
            end
        end
    end

    logic gt, eq, c_next, err_next;

    always_comb begin
        gt       = $signed(s1.a_al) > $signed(s1.b_al);
        eq       = s1.a_al == s1.b_al;
        c_next   = 1'b0;
        err_next = 1'b0;
        case (s1.op)
            OP_GT:   c_next = gt;
            OP_GE:   c_next = gt | eq;
            OP_LT:   c_next = ~(gt | eq);
            OP_LE:   c_next = ~gt;
            OP_EQ:   c_next = eq;
            OP_NE:   c_next = ~eq;
            default: err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else if (cke) begin
            s1 <= '{valid: advance, id: sel_id, op: sel_op, a_al: sel_a, b_al: sel_b};
            s2 <= '{valid: s1.valid, id: s1.id, c: c_next, err: err_next};
        end
    end

    assign rsp_c   = s2.c;
    assign rsp_err = s2.err;

    always_comb begin
        for (int i = 0; i < n_req; i++)
            rsp_valid[i] = cke && !rst && s2.valid && (s2.id == ID_MAX_W'(i));
    end

`ifdef COMP_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_done <= '0;
            stat_err  <= '0;
        end else if (cke && s2.valid) begin
            stat_done <= stat_done + 32'd1;
            if (s2.err && stat_err != 16'hFFFF)
                stat_err <= stat_err + 16'd1;
        end
    end
`endif
endmodule
